mem_dump_scanner: RTL

Debug-bus reader for the CPU memory block: on a start request it walks the data-memory debug port (`mem_check_addr` / `mem_check_data`) over a programmed word range and streams each word, tagged with its address, to a downstream consumer (UART transmitter, segment display pager) through a valid/ready handshake. It sits beside the CPU on the debug side. It is the only driver of `mem_check_addr` and never touches the CPU instruction or data ports.

---
 rtl/mem_dump_scanner_pkg.sv | 18 +
 rtl/mem_dump_scanner.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_dump_scanner_pkg.sv
// Shared definitions for the debug-side memory dump logic.
//   state_e      : dump sequencer states
//   addr_t       : 32-bit word index on the memory debug port
//   DEFAULT_STEP : address increment per dumped word (word-indexed port)
package mem_dump_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef logic [31:0] addr_t;

   localparam int unsigned DEFAULT_STEP = 1;

endpackage : mem_dump_scanner_pkg

// File: rtl/mem_dump_scanner.sv
// Walks the memory debug read port over [base_addr, base_addr+word_count)
// and streams each word with its address through a valid/ready handshake.
//
// Ports
//   clk, rstn          : clock, async active-low reset
//   start              : request pulse, honoured only when idle
//   base_addr          : first word index (sampled with start)
//   word_count         : number of words (sampled with start)
//   mem_check_addr     : debug read address to the memory block
//   mem_check_data     : debug read data (combinational in mem_check_addr)
//   out_valid/ready    : output handshake
//   out_data/out_addr  : captured word and its address
//   out_last           : marks the final word
//   busy               : high whenever not idle
//   done               : one-cycle completion pulse
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; mem_check_addr holds its last value
// ST_FETCH | address stable for one cycle, word captured at its end
// ST_SEND  | word presented on out_*, frozen until accepted
// ST_DONE  | single-cycle done pulse, then back to idle
module mem_dump_scanner
   import mem_dump_scanner_pkg::*;
#(
   parameter int unsigned STEP    = DEFAULT_STEP,
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic [31:0]        base_addr,
   input  logic [COUNT_W-1:0] word_count,
   output logic [31:0]        mem_check_addr,
   input  logic [31:0]        mem_check_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic [31:0]        out_addr,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   state_e             state;
   addr_t              addr_q;
   logic [COUNT_W-1:0] remaining;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     addr_q    <= base_addr;
                     remaining <= word_count;
                     state     <= ST_FETCH;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_FETCH: begin
               out_data <= mem_check_data;
               out_addr <= addr_q;
               out_last <= (remaining == COUNT_W'(1));
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (out_ready) begin
                  if (out_last) begin
                     state <= ST_DONE;
                  end else begin
                     // 32-bit add wraps silently past 0xFFFF_FFFF
                     addr_q    <= addr_q + 32'(STEP);
                     remaining <= remaining - COUNT_W'(1);
                     state     <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_check_addr = addr_q;
   assign out_valid      = (state == ST_SEND);
   assign busy           = (state != ST_IDLE);
   assign done           = (state == ST_DONE);

endmodule : mem_dump_scanner
